// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and next-PC select encoding for the fetch stage
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_LOAD,
        SEL_HOLD,
        SEL_JR,
        SEL_J,
        SEL_BR,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - control, program-load and IF/ID signals of the fetch stage
interface instruction_fetch_if #(
    parameter int SIZE      = 32,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
);
    logic              i_stall;
    logic              i_jump;
    logic [25:0]       i_jump_dir;
    logic              i_branch;
    logic [SIZE-1:0]   i_branch_target;
    logic              i_jump_reg;
    logic [SIZE-1:0]   i_jr_target;
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic [SIZE-1:0]   i_load_data;
    logic [SIZE-1:0]   o_pc;
    logic [SIZE-1:0]   o_instruction;
    logic [SIZE-1:0]   o_pc_next;
    logic              o_halt;

    modport master (
        output i_stall, i_jump, i_jump_dir, i_branch, i_branch_target,
               i_jump_reg, i_jr_target, i_load_en, i_load_addr, i_load_data,
        input  o_pc, o_instruction, o_pc_next, o_halt
    );

    modport slave (
        input  i_stall, i_jump, i_jump_dir, i_branch, i_branch_target,
               i_jump_reg, i_jr_target, i_load_en, i_load_addr, i_load_data,
        output o_pc, o_instruction, o_pc_next, o_halt
    );
endinterface

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - program memory: synchronous write port, combinational read port
module instruction_memory #(
    parameter int SIZE      = 32,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SIZE-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SIZE-1:0]   rdata
);
    // No reset: program contents survive rst.
    logic [SIZE-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC, next-PC mux, IF/ID register; halt detection under IF_HALT_DETECT_EN
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    instruction_fetch_if.slave bus
);
    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0] if_pc_q, if_pc_d;
    logic [SIZE-1:0] if_instr_q, if_instr_d;
    logic [SIZE-1:0] mem_word;
    logic            halt_q, halt_d;
    logic            halt_hit;
    pc_sel_e         pc_sel;

    instruction_memory #(
        .SIZE      (SIZE),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (bus.i_load_en),
        .waddr (bus.i_load_addr),
        .wdata (bus.i_load_data),
        .raddr (pc_q[ADDR_W-1:0]),
        .rdata (mem_word)
    );

    always_comb begin
        pc_sel = SEL_SEQ;
        if (bus.i_load_en) begin
            pc_sel = SEL_LOAD;
        end else if (bus.i_stall) begin
            pc_sel = SEL_HOLD;
        end else if (bus.i_jump_reg) begin
            pc_sel = SEL_JR;
        end else if (bus.i_jump) begin
            pc_sel = SEL_J;
        end else if (bus.i_branch) begin
            pc_sel = SEL_BR;
        end
    end

`ifdef IF_HALT_DETECT_EN
    // Only a plain sequential fetch can see the halt word; redirects win.
    assign halt_hit = (pc_sel == SEL_SEQ) && (mem_word == HALT_WORD);
`else
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        halt_d     = halt_q;
        case (pc_sel)
            SEL_LOAD: begin
                pc_d       = '0;
                if_pc_d    = '0;
                if_instr_d = NOP_WORD;
                halt_d     = 1'b0;
            end
            SEL_HOLD: begin
            end
            default: begin
                if (halt_q || halt_hit) begin
                    if_pc_d    = '0;
                    if_instr_d = NOP_WORD;
                    halt_d     = 1'b1;
                end else if (pc_sel == SEL_SEQ) begin
                    pc_d       = pc_q + 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = mem_word;
                end else begin
                    // Redirect: squash the wrong-path word with a bubble.
                    if_pc_d    = '0;
                    if_instr_d = NOP_WORD;
                    case (pc_sel)
                        SEL_JR:  pc_d = bus.i_jr_target;
                        SEL_J:   pc_d = {if_pc_q[SIZE-1:26], bus.i_jump_dir};
                        default: pc_d = bus.i_branch_target;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_WORD;
            halt_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            halt_q     <= halt_d;
        end
    end

    assign bus.o_pc          = if_pc_q;
    assign bus.o_instruction = if_instr_q;
    assign bus.o_pc_next     = pc_q;
    assign bus.o_halt        = halt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed plus randomized check of instruction_fetch against a reference model
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int SIZE      = 32;
    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 6;
`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if #(.SIZE(SIZE), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) bus ();

    instruction_fetch #(.SIZE(SIZE), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [MEM_DEPTH];
    logic [31:0] m_pc, m_opc, m_instr;
    logic        m_halt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge of the fetch stage, from the priority rules.
    task automatic model_step();
        logic [31:0] word;
        int          idx;
        if (rst) begin
            m_pc = 0; m_opc = 0; m_instr = 0; m_halt = 1'b0;
            if (bus.i_load_en) m_mem[int'(bus.i_load_addr)] = bus.i_load_data;
        end else if (bus.i_load_en) begin
            m_mem[int'(bus.i_load_addr)] = bus.i_load_data;
            m_pc = 0; m_opc = 0; m_instr = 0; m_halt = 1'b0;
        end else if (bus.i_stall) begin
        end else if (m_halt) begin
            m_opc = 0; m_instr = 0;
        end else if (bus.i_jump_reg || bus.i_jump || bus.i_branch) begin
            if (bus.i_jump_reg)  m_pc = bus.i_jr_target;
            else if (bus.i_jump) m_pc = {m_opc[31:26], bus.i_jump_dir};
            else                 m_pc = bus.i_branch_target;
            m_opc = 0; m_instr = 0;
        end else begin
            idx  = int'(m_pc % 32'd64);
            word = m_mem[idx];
            if (HALT_EN && word == 32'hFFFF_FFFF) begin
                m_halt = 1'b1; m_opc = 0; m_instr = 0;
            end else begin
                m_opc = m_pc; m_instr = word; m_pc = m_pc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("m_pc",     bus.o_pc,          m_opc);
        check_eq("m_instr",  bus.o_instruction, m_instr);
        check_eq("m_pcnext", bus.o_pc_next,     m_pc);
        check_eq("m_halt",   {31'b0, bus.o_halt}, {31'b0, m_halt});
    endtask

    task automatic clear_in();
        bus.i_stall = 0; bus.i_jump = 0; bus.i_jump_dir = '0; bus.i_branch = 0;
        bus.i_branch_target = '0; bus.i_jump_reg = 0; bus.i_jr_target = '0;
        bus.i_load_en = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        logic [31:0] a;
        a = addr;
        bus.i_load_en = 1; bus.i_load_addr = a[ADDR_W-1:0]; bus.i_load_data = data;
        tick();
        bus.i_load_en = 0;
    endtask

    initial begin
        logic [31:0] r;
        m_pc = 0; m_opc = 0; m_instr = 0; m_halt = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 0;
        clear_in();
        rst = 1;
        tick();
        tick();
        check_eq("rst_pc",      bus.o_pc,          32'd0);
        check_eq("rst_instr",   bus.o_instruction, 32'd0);
        check_eq("rst_pc_next", bus.o_pc_next,     32'd0);
        check_eq("rst_halt",    {31'b0, bus.o_halt}, 32'd0);
        rst = 0;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (i < 4)        r = 32'h11 * (i + 1);
            else if (i == 10) r = 32'hAA;
            else              r = $urandom() & 32'h7FFF_FFFF;
            load_word(i, r);
        end

        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("seq_instr", bus.o_instruction, 32'h11 * (k + 1));
            check_eq("seq_pc",    bus.o_pc,          k);
        end

        load_word(50, $urandom() & 32'h7FFF_FFFF);
        tick();
        tick();
        check_eq("pre_stall_instr", bus.o_instruction, 32'h22);
        bus.i_stall = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("stall_pc",    bus.o_pc,          32'd1);
            check_eq("stall_instr", bus.o_instruction, 32'h22);
        end
        bus.i_stall = 0;
        tick();
        check_eq("unstall_instr", bus.o_instruction, 32'h33);
        check_eq("unstall_pc",    bus.o_pc,          32'd2);

        bus.i_branch = 1; bus.i_branch_target = 32'd10;
        tick();
        clear_in();
        check_eq("br_bubble_instr", bus.o_instruction, 32'd0);
        check_eq("br_bubble_pc",    bus.o_pc,          32'd0);
        check_eq("br_pc_next",      bus.o_pc_next,     32'd10);
        tick();
        check_eq("br_target_instr", bus.o_instruction, 32'hAA);
        check_eq("br_target_pc",    bus.o_pc,          32'd10);

        bus.i_jump = 1; bus.i_jump_dir = 26'd20; bus.i_branch = 1; bus.i_branch_target = 32'd30;
        tick();
        check_eq("j_over_br", bus.o_pc_next, 32'd20);
        bus.i_stall = 1; bus.i_jump_dir = 26'd40; bus.i_branch_target = 32'd50;
        tick();
        check_eq("stall_over_j", bus.o_pc_next, 32'd20);
        clear_in();
        tick();
        check_eq("j_target_pc", bus.o_pc, 32'd20);

        bus.i_jump_reg = 1; bus.i_jr_target = 32'd63;
        tick();
        clear_in();
        check_eq("jr_pc_next", bus.o_pc_next, 32'd63);
        tick();
        check_eq("pc63",       bus.o_pc,      32'd63);
        check_eq("pc_next64",  bus.o_pc_next, 32'd64);
        tick();
        check_eq("wrap_pc",    bus.o_pc,          32'd64);
        check_eq("wrap_instr", bus.o_instruction, 32'h11);

        load_word(2, HALT_WORD);
        tick();
        tick();
        check_eq("pre_halt_pc_next", bus.o_pc_next, 32'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef IF_HALT_DETECT_EN
            check_eq("halt_flag",    {31'b0, bus.o_halt}, 32'd1);
            check_eq("halt_instr",   bus.o_instruction,  32'd0);
            check_eq("halt_pc_next", bus.o_pc_next,      32'd2);
`else
            check_eq("nohalt_flag",  {31'b0, bus.o_halt}, 32'd0);
            check_eq("nohalt_pc",    bus.o_pc,           32'd2 + k);
`endif
        end
        rst = 1;
        tick();
        rst = 0;
        check_eq("halt_rst_flag", {31'b0, bus.o_halt}, 32'd0);
        check_eq("halt_rst_pc",   bus.o_pc_next,      32'd0);

        for (int c = 0; c < 400; c++) begin
            clear_in();
            rst = ($urandom_range(0, 63) == 0);
            if (!rst && $urandom_range(0, 15) == 0) begin
                r = $urandom();
                bus.i_load_en   = 1;
                bus.i_load_addr = r[ADDR_W-1:0];
                bus.i_load_data = ($urandom_range(0, 7) == 0) ? HALT_WORD : ($urandom() & 32'h7FFF_FFFF);
            end
            bus.i_stall    = ($urandom_range(0, 3) == 0);
            bus.i_jump_reg = ($urandom_range(0, 7) == 0);
            bus.i_jump     = ($urandom_range(0, 7) == 0);
            bus.i_branch   = ($urandom_range(0, 7) == 0);
            r = $urandom();
            bus.i_jump_dir      = r[25:0];
            bus.i_branch_target = $urandom_range(0, 200);
            bus.i_jr_target     = $urandom();
            tick();
        end
        rst = 0;
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
